// File: rtl/match_controller_pkg.sv
// match_controller_pkg: shared constants and types for the round/match
// sequencer. FSM state codes, round/match winner codes, health width and the
// idle player-input code, alongside the game-wide INPUT_DEPTH/STATE_DEPTH.
package match_controller_pkg;

  localparam int INPUT_DEPTH  = 5;
  localparam int STATE_DEPTH  = 3;
  localparam int HEALTH_DEPTH = 7;

  // Player input code meaning "no button pressed"
  localparam logic [INPUT_DEPTH-1:0] NOTHING = '0;

  typedef enum logic [STATE_DEPTH-1:0] {
    ST_IDLE       = 3'd0,
    ST_PLAYER_RST = 3'd1,
    ST_COUNTDOWN  = 3'd2,
    ST_FIGHT      = 3'd3,
    ST_KO         = 3'd4,
    ST_MATCH_OVER = 3'd5
  } match_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'b00,
    WIN_P1   = 2'b01,
    WIN_P2   = 2'b10,
    WIN_DRAW = 2'b11
  } winner_t;

  // Round-win counter stops at 3 instead of wrapping
  function automatic logic [1:0] sat_inc_wins(input logic [1:0] w);
    return (w == 2'd3) ? w : w + 2'd1;
  endfunction

  // Round number stops at 15 instead of wrapping
  function automatic logic [3:0] sat_inc_round(input logic [3:0] r);
    return (r == 4'd15) ? r : r + 4'd1;
  endfunction

endpackage

// File: rtl/match_controller_hit.sv
// hit_edge_counter: one player's health bar. Samples the opponent's
// attack-connected signal on qualifying frames, counts only a 0->1 change
// between consecutive samples, and removes DAMAGE per counted hit, stopping
// at zero. health_next exposes the value that will be registered so the
// sequencer can end the round on the same edge the health reaches zero.
module hit_edge_counter #(
  parameter int HEALTH_DEPTH = 7,
  parameter int MAX_HEALTH   = 100,
  parameter int DAMAGE       = 10
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic                    sample,
  input  logic                    connects,
  output logic [HEALTH_DEPTH-1:0] health,
  output logic [HEALTH_DEPTH-1:0] health_next
);

  localparam logic [HEALTH_DEPTH-1:0] FULL = HEALTH_DEPTH'(MAX_HEALTH);
  localparam logic [HEALTH_DEPTH-1:0] DMG  = HEALTH_DEPTH'(DAMAGE);

  logic                    prev_reg;
  logic [HEALTH_DEPTH-1:0] health_reg;
  logic                    hit;

  assign hit    = sample & connects & ~prev_reg;
  assign health = health_reg;

  // Next health: refill on load, otherwise saturating subtract on a hit
  always_comb begin
    health_next = health_reg;
    if (load) begin
      health_next = FULL;
    end else if (hit) begin
      health_next = (health_reg <= DMG) ? '0 : health_reg - DMG;
    end
  end

  // Connect history is forgotten on load so each round starts un-armed-free
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      prev_reg   <= 1'b0;
      health_reg <= FULL;
    end else begin
      if (load) begin
        prev_reg <= 1'b0;
      end else if (sample) begin
        prev_reg <= connects;
      end
      health_reg <= health_next;
    end
  end

endmodule

// File: rtl/match_controller.sv
// match_controller: round/match sequencer above game_logic. Holds game_logic
// in reset between rounds, gates player inputs, turns attack-connected pulses
// into health, round wins and a match winner, and runs countdown / KO hold /
// match-over sequencing for the HUD.
// Optional build macro ROUND_TIMER_EN adds a per-round seconds timer and the
// timer_sec output; when undefined rounds end only by KO.
module match_controller #(
  parameter int MAX_HEALTH       = 100,
  parameter int HEALTH_DEPTH     = match_controller_pkg::HEALTH_DEPTH,
  parameter int DAMAGE           = 10,
  parameter int ROUNDS_TO_WIN    = 2,
  parameter int COUNTDOWN_FRAMES = 180,
  parameter int KO_FRAMES        = 120,
  parameter int RESET_CYCLES     = 4
`ifdef ROUND_TIMER_EN
  ,
  parameter int FRAMES_PER_SEC   = 60,
  parameter int ROUND_SECONDS    = 99
`endif
) (
  input  logic                    sys_clk,
  input  logic                    rst,
  input  logic                    frame_tick,
  input  logic                    start,
  input  logic                    done_gen,
  input  logic                    p1_connects,
  input  logic                    p2_connects,
  output logic                    game_rst_n,
  output logic                    inputs_enable,
  output logic [HEALTH_DEPTH-1:0] p1_health,
  output logic [HEALTH_DEPTH-1:0] p2_health,
  output logic [1:0]              p1_wins,
  output logic [1:0]              p2_wins,
  output logic [3:0]              round_num,
  output logic [2:0]              match_state,
  output logic [1:0]              winner
`ifdef ROUND_TIMER_EN
  ,
  output logic [6:0]              timer_sec
`endif
);

  import match_controller_pkg::*;

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
  localparam logic [CNT_W-1:0] CD_LAST  = CNT_W'(COUNTDOWN_FRAMES - 1);
  localparam logic [CNT_W-1:0] KO_LAST  = CNT_W'(KO_FRAMES - 1);
  localparam logic [1:0]       WINS_TARGET = 2'(ROUNDS_TO_WIN);

  match_state_t      state_reg;
  winner_t           winner_reg;
  winner_t           round_result;
  logic              game_rst_n_reg;
  logic              inputs_enable_reg;
  logic [1:0]        p1_wins_reg;
  logic [1:0]        p2_wins_reg;
  logic [3:0]        round_reg;
  logic [CNT_W-1:0]  cnt_reg;

  logic              health_load;
  logic              fight_sample;
  logic              fight_tick;
  logic              round_ko;
  logic              round_end;
  logic [1:0]        attacker_connects;
  logic [HEALTH_DEPTH-1:0] health_q [2];
  logic [HEALTH_DEPTH-1:0] health_n [2];

  assign health_load  = (state_reg == ST_PLAYER_RST);
  assign fight_tick   = (state_reg == ST_FIGHT) & frame_tick;
  assign fight_sample = fight_tick & done_gen;

  // Index = victim: p1's bar (0) is hit by p2, p2's bar (1) is hit by p1
  assign attacker_connects = {p1_connects, p2_connects};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : gen_player
      hit_edge_counter #(
        .HEALTH_DEPTH (HEALTH_DEPTH),
        .MAX_HEALTH   (MAX_HEALTH),
        .DAMAGE       (DAMAGE)
      ) u_hit (
        .sys_clk     (sys_clk),
        .rst         (rst),
        .load        (health_load),
        .sample      (fight_sample),
        .connects    (attacker_connects[gi]),
        .health      (health_q[gi]),
        .health_next (health_n[gi])
      );
    end
  endgenerate

  assign round_ko = fight_sample && ((health_n[0] == '0) || (health_n[1] == '0));

`ifdef ROUND_TIMER_EN
  localparam logic [CNT_W-1:0] SEC_LAST = CNT_W'(FRAMES_PER_SEC - 1);

  logic [6:0]       timer_reg;
  logic [CNT_W-1:0] sec_cnt_reg;
  logic             timer_expire;

  // Expiry is the tick that takes the timer from 1 to 0
  assign timer_expire = fight_tick && (sec_cnt_reg == SEC_LAST) && (timer_reg == 7'd1);
  assign round_end    = round_ko | timer_expire;
  assign timer_sec    = timer_reg;

  // Seconds timer: loaded while players reset, counts down only in FIGHT
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      timer_reg   <= '0;
      sec_cnt_reg <= '0;
    end else if (state_reg == ST_PLAYER_RST) begin
      timer_reg   <= 7'(ROUND_SECONDS);
      sec_cnt_reg <= '0;
    end else if (fight_tick) begin
      if (sec_cnt_reg == SEC_LAST) begin
        sec_cnt_reg <= '0;
        if (timer_reg != 7'd0) begin
          timer_reg <= timer_reg - 7'd1;
        end
      end else begin
        sec_cnt_reg <= sec_cnt_reg + 1'b1;
      end
    end
  end
`else
  assign round_end = round_ko;
`endif

  // Round result from post-update health: a zeroed bar is always the lower
  // one, so KO and time-out share the same higher-health-wins rule
  always_comb begin
    round_result = WIN_DRAW;
    if (health_n[0] > health_n[1]) begin
      round_result = WIN_P1;
    end else if (health_n[0] < health_n[1]) begin
      round_result = WIN_P2;
    end
  end

  // Round/match sequencer with registered HUD and game_logic control outputs
  always_ff @(posedge sys_clk or negedge rst) begin
    if (!rst) begin
      state_reg         <= ST_IDLE;
      game_rst_n_reg    <= 1'b0;
      inputs_enable_reg <= 1'b0;
      p1_wins_reg       <= 2'd0;
      p2_wins_reg       <= 2'd0;
      round_reg         <= 4'd0;
      winner_reg        <= WIN_NONE;
      cnt_reg           <= '0;
    end else begin
      case (state_reg)
        ST_IDLE, ST_MATCH_OVER: begin
          if (start) begin
            state_reg         <= ST_PLAYER_RST;
            round_reg         <= 4'd1;
            p1_wins_reg       <= 2'd0;
            p2_wins_reg       <= 2'd0;
            cnt_reg           <= '0;
            game_rst_n_reg    <= 1'b0;
            inputs_enable_reg <= 1'b0;
          end
        end
        ST_PLAYER_RST: begin
          winner_reg <= WIN_NONE;
          if (cnt_reg == RST_LAST) begin
            state_reg      <= ST_COUNTDOWN;
            cnt_reg        <= '0;
            game_rst_n_reg <= 1'b1;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        ST_COUNTDOWN: begin
          if (frame_tick) begin
            if (cnt_reg == CD_LAST) begin
              state_reg         <= ST_FIGHT;
              cnt_reg           <= '0;
              inputs_enable_reg <= 1'b1;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        ST_FIGHT: begin
          if (round_end) begin
            state_reg         <= ST_KO;
            cnt_reg           <= '0;
            inputs_enable_reg <= 1'b0;
            winner_reg        <= round_result;
            if (round_result == WIN_P1) begin
              p1_wins_reg <= sat_inc_wins(p1_wins_reg);
            end
            if (round_result == WIN_P2) begin
              p2_wins_reg <= sat_inc_wins(p2_wins_reg);
            end
          end
        end
        ST_KO: begin
          if (frame_tick) begin
            if (cnt_reg == KO_LAST) begin
              cnt_reg <= '0;
              if (p1_wins_reg == WINS_TARGET) begin
                state_reg  <= ST_MATCH_OVER;
                winner_reg <= WIN_P1;
              end else if (p2_wins_reg == WINS_TARGET) begin
                state_reg  <= ST_MATCH_OVER;
                winner_reg <= WIN_P2;
              end else begin
                state_reg      <= ST_PLAYER_RST;
                round_reg      <= sat_inc_round(round_reg);
                game_rst_n_reg <= 1'b0;
              end
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end
        end
        default: begin
          state_reg         <= ST_IDLE;
          game_rst_n_reg    <= 1'b0;
          inputs_enable_reg <= 1'b0;
        end
      endcase
    end
  end

  assign game_rst_n    = game_rst_n_reg;
  assign inputs_enable = inputs_enable_reg;
  assign p1_health     = health_q[0];
  assign p2_health     = health_q[1];
  assign p1_wins       = p1_wins_reg;
  assign p2_wins       = p2_wins_reg;
  assign round_num     = round_reg;
  assign match_state   = state_reg;
  assign winner        = winner_reg;

endmodule

// File: tb/tb_match_controller.sv
// tb_match_controller: directed bench for match_controller with an
// event-level reference model compared on every clock, plus hand-computed
// literal expectations at the key points of each round.
`timescale 1ns/1ps
module tb_match_controller;

  localparam int MAXH = 100;
  localparam int DMG  = 10;
  localparam int RTW  = 2;
  localparam int CDF  = 180;
  localparam int KOF  = 120;
  localparam int RSTC = 4;
`ifdef ROUND_TIMER_EN
  localparam int FPS  = 2;
  localparam int SECS = 40;
`endif

  logic       sys_clk = 1'b0;
  logic       rst = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start = 1'b0;
  logic       done_gen = 1'b1;
  logic       p1_connects = 1'b0;
  logic       p2_connects = 1'b0;
  logic       game_rst_n;
  logic       inputs_enable;
  logic [6:0] p1_health;
  logic [6:0] p2_health;
  logic [1:0] p1_wins;
  logic [1:0] p2_wins;
  logic [3:0] round_num;
  logic [2:0] match_state;
  logic [1:0] winner;
`ifdef ROUND_TIMER_EN
  logic [6:0] timer_sec;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  match_controller #(
    .MAX_HEALTH       (MAXH),
    .HEALTH_DEPTH     (7),
    .DAMAGE           (DMG),
    .ROUNDS_TO_WIN    (RTW),
    .COUNTDOWN_FRAMES (CDF),
    .KO_FRAMES        (KOF),
    .RESET_CYCLES     (RSTC)
`ifdef ROUND_TIMER_EN
    ,
    .FRAMES_PER_SEC   (FPS),
    .ROUND_SECONDS    (SECS)
`endif
  ) dut (
    .sys_clk       (sys_clk),
    .rst           (rst),
    .frame_tick    (frame_tick),
    .start         (start),
    .done_gen      (done_gen),
    .p1_connects   (p1_connects),
    .p2_connects   (p2_connects),
    .game_rst_n    (game_rst_n),
    .inputs_enable (inputs_enable),
    .p1_health     (p1_health),
    .p2_health     (p2_health),
    .p1_wins       (p1_wins),
    .p2_wins       (p2_wins),
    .round_num     (round_num),
    .match_state   (match_state),
    .winner        (winner)
`ifdef ROUND_TIMER_EN
    ,
    .timer_sec     (timer_sec)
`endif
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (event level) ----------------
  int m_st, m_h1, m_h2, m_w1, m_w2, m_rnd, m_win, m_left, m_tmr, m_sub;
  bit m_prev1, m_prev2;

  function automatic int min_i(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_reset();
    m_st = 0; m_h1 = MAXH; m_h2 = MAXH; m_w1 = 0; m_w2 = 0; m_rnd = 0;
    m_win = 0; m_left = 0; m_prev1 = 0; m_prev2 = 0; m_tmr = 0; m_sub = 0;
  endtask

  task automatic end_round(input int result);
    m_st = 4; m_left = KOF; m_win = result;
    if (result == 1) m_w1 = min_i(m_w1 + 1, 3);
    if (result == 2) m_w2 = min_i(m_w2 + 1, 3);
  endtask

  task automatic model_step();
    bit expire;
    expire = 0;
    case (m_st)
      0, 5: if (start) begin
        m_st = 1; m_rnd = 1; m_w1 = 0; m_w2 = 0; m_left = RSTC;
      end
      1: begin
        m_h1 = MAXH; m_h2 = MAXH; m_win = 0; m_prev1 = 0; m_prev2 = 0;
`ifdef ROUND_TIMER_EN
        m_tmr = SECS; m_sub = FPS;
`endif
        m_left--;
        if (m_left == 0) begin m_st = 2; m_left = CDF; end
      end
      2: if (frame_tick) begin
        m_left--;
        if (m_left == 0) m_st = 3;
      end
      3: begin
        if (frame_tick && done_gen) begin
          if (p1_connects && !m_prev1) m_h2 = (m_h2 > DMG) ? m_h2 - DMG : 0;
          if (p2_connects && !m_prev2) m_h1 = (m_h1 > DMG) ? m_h1 - DMG : 0;
          m_prev1 = p1_connects;
          m_prev2 = p2_connects;
        end
`ifdef ROUND_TIMER_EN
        if (frame_tick) begin
          m_sub--;
          if (m_sub == 0) begin
            m_sub = FPS;
            if (m_tmr > 0) begin
              m_tmr--;
              if (m_tmr == 0) expire = 1;
            end
          end
        end
`endif
        if (m_h1 == 0 && m_h2 == 0) end_round(3);
        else if (m_h2 == 0)         end_round(1);
        else if (m_h1 == 0)         end_round(2);
        else if (expire)            end_round((m_h1 > m_h2) ? 1 : (m_h1 < m_h2) ? 2 : 3);
      end
      4: if (frame_tick) begin
        m_left--;
        if (m_left == 0) begin
          if (m_w1 == RTW)      begin m_st = 5; m_win = 1; end
          else if (m_w2 == RTW) begin m_st = 5; m_win = 2; end
          else begin m_rnd = min_i(m_rnd + 1, 15); m_st = 1; m_left = RSTC; end
        end
      end
      default: m_st = 0;
    endcase
  endtask

  task automatic compare_all();
    check("state",      match_state,   m_st);
    check("game_rst_n", game_rst_n,    (m_st >= 2) ? 1 : 0);
    check("inputs_en",  inputs_enable, (m_st == 3) ? 1 : 0);
    check("p1_health",  p1_health,     m_h1);
    check("p2_health",  p2_health,     m_h2);
    check("p1_wins",    p1_wins,       m_w1);
    check("p2_wins",    p2_wins,       m_w2);
    check("round_num",  round_num,     m_rnd);
    check("winner",     winner,        m_win);
`ifdef ROUND_TIMER_EN
    check("timer_sec",  timer_sec,     m_tmr);
`endif
  endtask

  // Single compare process: advance the model and check just after each edge
  initial begin
    model_reset();
    forever begin
      @(posedge sys_clk);
      #1;
      if (!rst) model_reset();
      else      model_step();
      compare_all();
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge sys_clk); frame_tick = 1'b1;
      @(negedge sys_clk); frame_tick = 1'b0;
    end
  endtask

  task automatic pulse(input bit a, input bit b, input int n);
    for (int i = 0; i < n; i++) begin
      p1_connects = a; p2_connects = b;
      ticks(1);
      p1_connects = 1'b0; p2_connects = 1'b0;
      ticks(1);
    end
  endtask

  task automatic wait_state(input int target, input int budget);
    int i;
    i = 0;
    while (int'(match_state) != target && i < budget) begin
      ticks(1);
      i++;
    end
    check("wait_state", match_state, target);
  endtask

  task automatic press_start();
    @(negedge sys_clk); start = 1'b1;
    @(negedge sys_clk); start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst = 1'b0;
    repeat (3) @(negedge sys_clk);
    check("L_rst_state",  match_state, 0);
    check("L_rst_grn",    game_rst_n, 0);
    check("L_rst_en",     inputs_enable, 0);
    check("L_rst_h1",     p1_health, 100);
    check("L_rst_round",  round_num, 0);
    rst = 1'b1;
    @(negedge sys_clk);

    // Start: four cycles of player reset, then countdown
    press_start();
    check("L_prst_state", match_state, 1);
    check("L_prst_grn",   game_rst_n, 0);
    repeat (3) @(negedge sys_clk);
    check("L_prst4_state", match_state, 1);
    @(negedge sys_clk);
    check("L_cd_state",   match_state, 2);
    check("L_cd_grn",     game_rst_n, 1);

    // Countdown ticks without done_gen still count
    done_gen = 1'b0; ticks(10);
    done_gen = 1'b1; ticks(169);
    check("L_cd179_state", match_state, 2);
    ticks(1);
    check("L_fight_state", match_state, 3);
    check("L_fight_en",    inputs_enable, 1);
    check("L_fight_round", round_num, 1);

    // Held connect: no hit without done_gen, then counted once
    p1_connects = 1'b1; done_gen = 1'b0; ticks(1);
    check("L_nodone_h2", p2_health, 100);
    done_gen = 1'b1; ticks(5);
    check("L_held_h2", p2_health, 90);
    p1_connects = 1'b0; ticks(1);
    pulse(1'b1, 1'b0, 9);
    check("L_ko_h2",     p2_health, 0);
    check("L_ko_winner", winner, 1);
    check("L_ko_w1",     p1_wins, 1);
    check("L_ko_state",  match_state, 4);

    // Round 2: simultaneous final hits give a draw
    wait_state(1, 200);
    check("L_r2_round", round_num, 2);
    wait_state(3, 400);
    pulse(1'b1, 1'b1, 9);
    check("L_r2_h1", p1_health, 10);
    check("L_r2_h2", p2_health, 10);
    pulse(1'b1, 1'b1, 1);
    check("L_draw_h1",     p1_health, 0);
    check("L_draw_h2",     p2_health, 0);
    check("L_draw_winner", winner, 3);
    check("L_draw_w1",     p1_wins, 1);
    check("L_draw_w2",     p2_wins, 0);
    wait_state(1, 200);
    check("L_r3_round", round_num, 3);
    wait_state(2, 10);
    check("L_r3_h1", p1_health, 100);
    check("L_r3_h2", p2_health, 100);

    // Round 3: p1 takes the match
    wait_state(3, 400);
    pulse(1'b1, 1'b0, 10);
    check("L_r3_w1", p1_wins, 2);
    wait_state(5, 200);
    check("L_mo_winner", winner, 1);
    check("L_mo_en",     inputs_enable, 0);
    press_start();
    check("L_rs_state", match_state, 1);
    check("L_rs_round", round_num, 1);
    check("L_rs_w1",    p1_wins, 0);

    // Asynchronous reset mid-fight
    wait_state(3, 400);
    pulse(1'b0, 1'b1, 6);
    check("L_pre_rst_h1", p1_health, 40);
    @(negedge sys_clk);
    rst = 1'b0;
    #1;
    check("L_arst_grn",   game_rst_n, 0);
    check("L_arst_h1",    p1_health, 100);
    check("L_arst_state", match_state, 0);
    check("L_arst_en",    inputs_enable, 0);
    repeat (2) @(negedge sys_clk);
    rst = 1'b1;
    @(negedge sys_clk);

`ifdef ROUND_TIMER_EN
    // Time-out: higher health wins
    press_start();
    wait_state(3, 400);
    check("L_tmr_load", timer_sec, SECS);
    pulse(1'b0, 1'b1, 3);
    pulse(1'b1, 1'b0, 2);
    check("L_tmr_h1", p1_health, 70);
    check("L_tmr_h2", p2_health, 80);
    check("L_tmr_mid", timer_sec, SECS - 5);
    wait_state(4, 200);
    check("L_tmr_zero",   timer_sec, 0);
    check("L_tmr_winner", winner, 2);
`endif

    repeat (2) @(negedge sys_clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
- Round/match sequencer sitting above game_logic.
- Drives game_logic's reset and gates player inputs.
- Converts the p1/p2 attack-connected pulses into health, round wins and a match winner.
- Owns countdown, KO hold and match-over sequencing; all outputs feed HUD rendering.

Parameters:
- MAX_HEALTH, 100, starting health per round.
- HEALTH_DEPTH, 7, health register width (must hold MAX_HEALTH).
- DAMAGE, 10, health removed per counted hit.
- ROUNDS_TO_WIN, 2, round wins that end the match.
- COUNTDOWN_FRAMES, 180, frame ticks of frozen countdown before FIGHT.
- KO_FRAMES, 120, frame ticks of frozen hold after a round ends.
- RESET_CYCLES, 4, sys_clk cycles game_rst_n is held low per round.
- FRAMES_PER_SEC, 60, frame ticks per timer second (ROUND_TIMER_EN only).
- ROUND_SECONDS, 99, round time limit (ROUND_TIMER_EN only).

Ports:
- sys_clk  in  1  system clock; sole clock.
- rst  in  1  asynchronous active-low reset.
- frame_tick  in  1  one-sys_clk-cycle pulse per video frame, synchronous to sys_clk.
- start  in  1  start request, level or pulse; honoured only in IDLE and MATCH_OVER.
- done_gen  in  1  game_logic next-state generation complete for the current frame.
- p1_connects  in  1  p1 attack connected (from hit_calculator).
- p2_connects  in  1  p2 attack connected.
- game_rst_n  out  1  active-low reset to game_logic.
- inputs_enable  out  1  1 = pass player buttons to game_logic; 0 = force NOTHING.
- p1_health  out  HEALTH_DEPTH  p1 remaining health.
- p2_health  out  HEALTH_DEPTH  p2 remaining health.
- p1_wins  out  2  p1 rounds won.
- p2_wins  out  2  p2 rounds won.
- round_num  out  4  current round, 1-based; 0 in IDLE.
- match_state  out  3  FSM state code.
- winner  out  2  00 none, 01 p1, 10 p2, 11 draw; round result in KO, match result in MATCH_OVER.

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE; game_rst_n=0; inputs_enable=0; p1_health and p2_health=MAX_HEALTH; wins=0; round_num=0; winner=00; all counters=0.
- Reset mid-operation aborts immediately; nothing is preserved.
- All logic is registered on posedge sys_clk; outputs change one cycle after the causing event.
- State codes: IDLE=0, PLAYER_RST=1, COUNTDOWN=2, FIGHT=3, KO=4, MATCH_OVER=5.
- IDLE:
  - game_rst_n=0.
  - On start=1 -> PLAYER_RST; round_num<=1; wins<=0.
- PLAYER_RST:
  - game_rst_n=0 for exactly RESET_CYCLES cycles.
  - Health<=MAX_HEALTH; winner<=00.
  - Then -> COUNTDOWN.
- COUNTDOWN:
  - game_rst_n=1; inputs_enable=0.
  - Counts frame_tick; after COUNTDOWN_FRAMES ticks -> FIGHT.
- FIGHT, inputs_enable=1; hit counting:
  - Sampled only on a cycle with frame_tick=1 and done_gen=1.
  - A hit counts on the rising edge of connects between consecutive such samples, so a held connect counts once.
  - p1 hit reduces p2_health by DAMAGE; p2 hit reduces p1_health by DAMAGE.
  - Health saturates at 0 (no wrap).
  - Hits by both players in the same sample are both applied.
- FIGHT, round end after a health update:
  - One health 0 -> other player wins the round; winner set; that player's wins++ (saturating at 3) -> KO.
  - Both 0 -> winner=11 (draw); no wins awarded -> KO.
- KO:
  - inputs_enable=0; game_rst_n=1 (players freeze).
  - After KO_FRAMES ticks: any wins==ROUNDS_TO_WIN -> MATCH_OVER with winner = match winner. Otherwise round_num++ (saturating at 15) -> PLAYER_RST.
  - A draw round is replayed as a new round number.
- MATCH_OVER:
  - inputs_enable=0; outputs hold.
  - start=1 -> PLAYER_RST with round_num<=1, wins<=0.
- start in other states is ignored.
- frame_tick with done_gen=0 advances the COUNTDOWN/KO counters but counts no hits.

Optional Feature:
- Macro: ROUND_TIMER_EN.
- Defined:
  - Adds a seconds timer, loaded with ROUND_SECONDS in PLAYER_RST.
  - Decrements once per FRAMES_PER_SEC frame ticks, in FIGHT only.
  - Exposed on extra port timer_sec (out, 7).
  - When the timer reaches 0 in FIGHT -> KO; higher health wins; equal health = draw (11).
  - A KO on the same tick as expiry takes priority.
- Undefined:
  - No timer_sec port; rounds end only by KO.

Decomposition:
- Shared package/header: FSM state codes, winner codes, HEALTH_DEPTH, the NOTHING input code.
- These join the existing params.vh constants (INPUT_DEPTH, STATE_DEPTH).
- One sub-module: hit_edge_counter, per player; holds the sampled connect register and the saturating health decrement.
- The FSM stays in match_controller.

Test Plan:
- Reset, then start=1 one cycle -> game_rst_n low 4 cycles; match_state 1 -> 2; after 180 ticks -> 3; inputs_enable=1; round_num=1.
- FIGHT: p1_connects held high across 5 qualifying ticks -> p2_health 100 -> 90 once only. Pulse it 10 separate times -> p2_health=0; winner=01; p1_wins=1; state=4.
- Same-tick both connects with both health=10 -> both 0; winner=11; wins unchanged; after 120 ticks round_num increments; health back to 100.
- p1 wins 2 rounds -> MATCH_OVER; winner=01; start -> round_num=1, wins=0, state=1.
- Assert rst during FIGHT with p1_health=40 -> same cycle: game_rst_n=0, health=100, state=0.
- ROUND_TIMER_EN, FRAMES_PER_SEC=2, ROUND_SECONDS=3: 6 ticks in FIGHT with p1_health=70, p2_health=80 -> timer_sec=0; winner=10; state=4.
